selection_input: RTL and testbench
==================================

SELECTION_INPUT -- requirements
Module: selection_input

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive cycles a synchronized button level must differ from its debounced level before the debounced level changes; legal range 2..15.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 S0, S1, S2, S3  input  1 each  asynchronous beverage-select buttons, high = pressed.
REQ-005 SR, SP, SN  input  1 each  asynchronous sensor fault lines, high = fault.
REQ-006 VL  input  1  asynchronous payment-validated level, high = valid.
REQ-007 M  input  1  asynchronous maintenance mode, high = selections ignored.
REQ-008 ACK  input  1  display-side acknowledge, synchronous to CLK.
REQ-009 MSG  output  4  message code: 0 idle "...", 1 CE01, 2 CL02, 3 CC05, 4 CP10, 5 ERSR, 6 ERSP, 7 ERSN, 8 ERDI; codes 9..15 never driven.
REQ-010 MSG_VLD  output  1  high while MSG holds a message awaiting ACK.
REQ-011 DROP  output  1  one-cycle pulse when a selection event is discarded.

Function
REQ-012 Every asynchronous input SHALL pass through a two-flop synchronizer before any use.
REQ-013 Each of S0..S3 SHALL have a debounce counter: it increments on each edge where the synchronized level differs from the debounced level, and clears on any edge where they match.
REQ-014 A debounced level SHALL toggle on the edge where a mismatch is present and the counter equals DEB_CYCLES-1; the counter then clears.
REQ-015 A selection event SHALL be a debounced rising edge on exactly one of S0..S3, with the other three debounced levels low in that cycle.
REQ-016 Simultaneous debounced rising edges on two or more buttons, or a rising edge while another button is debounced-high, SHALL produce no event and no DROP.
REQ-017 The FSM SHALL have three states: IDLE, CHECK and HOLD.
REQ-018 IDLE: MSG=0 and MSG_VLD=0; a selection event with synchronized M=0 latches the button index and moves to CHECK.
REQ-019 IDLE: a selection event with synchronized M=1 SHALL be ignored, with no DROP.
REQ-020 CHECK lasts exactly one cycle and samples synchronized SR, SP, SN and VL.
REQ-021 CHECK code priority, highest first: SR=1 gives 5; else SP=1 gives 6; else SN=1 gives 7; else VL=0 gives 8; else the selection code (S0=1, S1=2, S2=3, S3=4).
REQ-022 CHECK registers the code into MSG, sets MSG_VLD=1 and moves to HOLD.
REQ-023 HOLD: MSG and MSG_VLD SHALL stay stable until an edge with ACK=1; that edge returns the FSM to IDLE with MSG=0 and MSG_VLD=0.
REQ-024 ACK in IDLE or CHECK SHALL be ignored.
REQ-025 A selection event arriving in CHECK or HOLD SHALL be discarded, with DROP high for that one cycle.
REQ-026 A change on M, SR, SP, SN or VL during HOLD SHALL NOT alter MSG.
REQ-027 Latency: MSG_VLD rises DEB_CYCLES+4 edges after the first edge that samples a clean button press (8 edges at the default).
REQ-028 A button held continuously SHALL generate only one event; a new event requires debounced release and then press.

Reset
REQ-029 With RST=1 at an edge, all of the following SHALL clear: the FSM to IDLE, MSG=0, MSG_VLD=0, DROP=0, all synchronizer flops, all debounce counters and all debounced levels.
REQ-030 RST SHALL take priority over every other input, including ACK and in-flight events.
REQ-031 Reset mid-CHECK or mid-HOLD SHALL abandon the message; the next edge after RST deasserts shows MSG=0.
REQ-032 A button held through reset release SHALL produce an event after debounce, because the debounced level restarts low.

Verification
REQ-033 Clean path: DEB=4, SR=SP=SN=0, VL=1, M=0, S2 pulsed high for 10 cycles -> MSG=3 with MSG_VLD=1 at edge 8; ACK one cycle -> MSG=0 and MSG_VLD=0 on the next edge.
REQ-034 Glitch reject: S0 high for 3 cycles, then low -> no event; MSG=0 throughout; S0 high for 4 cycles -> MSG=1.
REQ-035 Priority: SP=1, SN=1, VL=0 with an S3 press -> MSG=6; repeat with SR=SP=SN=0, VL=0 -> MSG=8.
REQ-036 Contention: S0 and S1 rise together -> no event and no DROP; in HOLD (MSG=2, ACK low) press S3 -> DROP pulses once and MSG stays 2.
REQ-037 Mode/reset: M=1 with an S1 press -> MSG=0; RST one cycle during HOLD -> MSG=0 and MSG_VLD=0 on the next edge, and a subsequent S1 press with M=0 -> MSG=2.

Source files
------------

// File: rtl/selection_input.sv
// selection_input
//   Beverage selection front end. Synchronizes the asynchronous panel inputs,
//   debounces the four select buttons, recognises single-button selection
//   events and turns each accepted selection into a message code that is held
//   until the display acknowledges it.
//
// Ports
//   CLK         sole clock, rising edge
//   RST         synchronous active-high reset
//   S0..S3      asynchronous select buttons, high = pressed
//   SR, SP, SN  asynchronous sensor fault lines, high = fault
//   VL          asynchronous payment-validated level, high = valid
//   M           asynchronous maintenance mode, high = selections ignored
//   ACK         display acknowledge, synchronous to CLK
//   MSG         message code (0 idle, 1..4 selection, 5..8 errors)
//   MSG_VLD     high while MSG awaits ACK
//   DROP        one-cycle pulse when a selection event is discarded
module selection_input #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       S0,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       SR,
  input  logic       SP,
  input  logic       SN,
  input  logic       VL,
  input  logic       M,
  input  logic       ACK,
  output logic [3:0] MSG,
  output logic       MSG_VLD,
  output logic       DROP
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  localparam logic [3:0] CODE_IDLE = 4'd0;
  localparam logic [3:0] CODE_ERSR = 4'd5;
  localparam logic [3:0] CODE_ERSP = 4'd6;
  localparam logic [3:0] CODE_ERSN = 4'd7;
  localparam logic [3:0] CODE_ERDI = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizers, bit order {M, VL, SN, SP, SR, S3, S2, S1, S0}
  // ---------------------------------------------------------------------
  logic [8:0] async_in;
  logic [8:0] meta;
  logic [8:0] sync;

  assign async_in = {M, VL, SN, SP, SR, S3, S2, S1, S0};

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= async_in;
      sync <= meta;
    end
  end

  logic [3:0] btn_s;
  logic       sr_s, sp_s, sn_s, vl_s, m_s;

  assign btn_s = sync[3:0];
  assign sr_s  = sync[4];
  assign sp_s  = sync[5];
  assign sn_s  = sync[6];
  assign vl_s  = sync[7];
  assign m_s   = sync[8];

  // ---------------------------------------------------------------------
  // Debounce: a level change is accepted after DEB_CYCLES consecutive
  // mismatching samples; any matching sample restarts the count.
  // ---------------------------------------------------------------------
  logic [3:0] cnt [4];
  logic [3:0] deb;
  logic [3:0] deb_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
      deb   <= '0;
      deb_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_s[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
      deb_q <= deb;
    end
  end

  // A selection event needs a rising debounced edge with exactly one
  // debounced level high; that level is then necessarily the rising one,
  // which rejects both simultaneous rises and a rise beside a held button.
  logic [3:0] rise;
  logic       sel_event;
  logic [1:0] sel_idx;

  assign rise      = deb & ~deb_q;
  assign sel_event = (|rise) && $onehot(deb);

  always_comb begin
    sel_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (deb[i]) begin
        sel_idx = 2'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Message FSM
  // ---------------------------------------------------------------------
  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [3:0] msg, msg_n;
  logic       vld, vld_n;
  logic       drop, drop_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      msg   <= CODE_IDLE;
      vld   <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      msg   <= msg_n;
      vld   <= vld_n;
      drop  <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    msg_n   = msg;
    vld_n   = vld;
    drop_n  = 1'b0;
    case (state)
      IDLE: begin
        msg_n = CODE_IDLE;
        vld_n = 1'b0;
        if (sel_event && !m_s) begin
          idx_n   = sel_idx;
          state_n = CHECK;
        end
      end
      CHECK: begin
        drop_n = sel_event;
        if (sr_s)       msg_n = CODE_ERSR;
        else if (sp_s)  msg_n = CODE_ERSP;
        else if (sn_s)  msg_n = CODE_ERSN;
        else if (!vl_s) msg_n = CODE_ERDI;
        else            msg_n = {2'b00, idx} + 4'd1;
        vld_n   = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        drop_n = sel_event;
        if (ACK) begin
          msg_n   = CODE_IDLE;
          vld_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        msg_n   = CODE_IDLE;
        vld_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign MSG     = msg;
  assign MSG_VLD = vld;
  assign DROP    = drop;

endmodule

// File: tb/tb_selection_input.sv
module tb_selection_input;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       S0 = 1'b0, S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
  logic       SR = 1'b0, SP = 1'b0, SN = 1'b0;
  logic       VL = 1'b1;
  logic       M = 1'b0;
  logic       ACK = 1'b0;
  logic [3:0] MSG;
  logic       MSG_VLD;
  logic       DROP;

  int pass_cnt = 0;
  int total_cnt = 0;

  selection_input #(.DEB_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3),
    .SR(SR), .SP(SP), .SN(SN), .VL(VL), .M(M),
    .ACK(ACK),
    .MSG(MSG), .MSG_VLD(MSG_VLD), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_vld();
    for (int k = 0; k < 20 && !MSG_VLD; k++) tick();
  endtask

  task automatic ack_and_settle();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(2);
    total_cnt++;
    if (MSG !== 4'd0) $display("FAIL reset_msg: got %0d want 0", MSG); else pass_cnt++;
    total_cnt++;
    if (MSG_VLD !== 1'b0) $display("FAIL reset_vld: got %b want 0", MSG_VLD); else pass_cnt++;
    total_cnt++;
    if (DROP !== 1'b0) $display("FAIL reset_drop: got %b want 0", DROP); else pass_cnt++;
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_clean_path();
    S2 = 1'b1;
    tick(7);
    total_cnt++;
    if (MSG_VLD !== 1'b0) $display("FAIL clean_early_vld: got %b want 0 at edge 7", MSG_VLD); else pass_cnt++;
    tick();
    total_cnt++;
    if (MSG_VLD !== 1'b1) $display("FAIL clean_vld_edge8: got %b want 1", MSG_VLD); else pass_cnt++;
    total_cnt++;
    if (MSG !== 4'd3) $display("FAIL clean_msg: got %0d want 3", MSG); else pass_cnt++;
    tick(2);
    S2 = 1'b0;
    tick(3);
    total_cnt++;
    if (MSG !== 4'd3 || MSG_VLD !== 1'b1)
      $display("FAIL clean_hold_stable: got msg=%0d vld=%b want 3/1", MSG, MSG_VLD); else pass_cnt++;
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    total_cnt++;
    if (MSG !== 4'd0 || MSG_VLD !== 1'b0)
      $display("FAIL clean_ack: got msg=%0d vld=%b want 0/0", MSG, MSG_VLD); else pass_cnt++;
    tick(10);
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    S0 = 1'b1;
    tick(3);
    S0 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (MSG !== 4'd0 || MSG_VLD !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL glitch_reject: got %0d cycles with message want 0", bad); else pass_cnt++;
    S0 = 1'b1;
    tick(4);
    S0 = 1'b0;
    wait_vld();
    total_cnt++;
    if (MSG_VLD !== 1'b1 || MSG !== 4'd1)
      $display("FAIL glitch_accept: got msg=%0d vld=%b want 1/1", MSG, MSG_VLD); else pass_cnt++;
    ack_and_settle();
  endtask

  task automatic test_priority();
    SP = 1'b1; SN = 1'b1; VL = 1'b0;
    tick(3);
    S3 = 1'b1;
    tick(6);
    S3 = 1'b0;
    wait_vld();
    total_cnt++;
    if (MSG !== 4'd6 || MSG_VLD !== 1'b1)
      $display("FAIL prio_ersp: got msg=%0d vld=%b want 6/1", MSG, MSG_VLD); else pass_cnt++;
    ack_and_settle();
    SP = 1'b0; SN = 1'b0; VL = 1'b0;
    tick(3);
    S3 = 1'b1;
    tick(6);
    S3 = 1'b0;
    wait_vld();
    total_cnt++;
    if (MSG !== 4'd8 || MSG_VLD !== 1'b1)
      $display("FAIL prio_erdi: got msg=%0d vld=%b want 8/1", MSG, MSG_VLD); else pass_cnt++;
    // Sensor/payment changes while holding must not disturb the message.
    SR = 1'b1; VL = 1'b1; M = 1'b1;
    tick(5);
    total_cnt++;
    if (MSG !== 4'd8) $display("FAIL hold_ignores_inputs: got %0d want 8", MSG); else pass_cnt++;
    SR = 1'b0; M = 1'b0;
    ack_and_settle();
  endtask

  task automatic test_contention();
    int drops;
    int bad;
    drops = 0;
    bad = 0;
    S0 = 1'b1; S1 = 1'b1;
    tick(6);
    S0 = 1'b0; S1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (DROP) drops++;
      if (MSG_VLD) bad++;
    end
    total_cnt++;
    if (drops !== 0 || bad !== 0)
      $display("FAIL contention_none: got drops=%0d vld_cycles=%0d want 0/0", drops, bad); else pass_cnt++;
    S1 = 1'b1;
    tick(6);
    S1 = 1'b0;
    wait_vld();
    total_cnt++;
    if (MSG !== 4'd2) $display("FAIL contention_setup: got %0d want 2", MSG); else pass_cnt++;
    tick(8);
    drops = 0;
    bad = 0;
    S3 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 5) S3 = 1'b0;
      if (DROP) drops++;
      if (MSG !== 4'd2 || MSG_VLD !== 1'b1) bad++;
    end
    total_cnt++;
    if (drops !== 1) $display("FAIL drop_count: got %0d want 1", drops); else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL drop_msg_stable: got %0d disturbed cycles want 0", bad); else pass_cnt++;
    ack_and_settle();
  endtask

  task automatic test_mode();
    int bad;
    bad = 0;
    M = 1'b1;
    tick(3);
    S1 = 1'b1;
    tick(6);
    S1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (MSG !== 4'd0 || MSG_VLD !== 1'b0 || DROP !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL mode_ignore: got %0d active cycles want 0", bad); else pass_cnt++;
    M = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_hold();
    S1 = 1'b1;
    wait_vld();
    total_cnt++;
    if (MSG !== 4'd2 || MSG_VLD !== 1'b1)
      $display("FAIL rst_hold_setup: got msg=%0d vld=%b want 2/1", MSG, MSG_VLD); else pass_cnt++;
    RST = 1'b1;
    ACK = 1'b1;
    tick();
    RST = 1'b0;
    ACK = 1'b0;
    total_cnt++;
    if (MSG !== 4'd0 || MSG_VLD !== 1'b0)
      $display("FAIL rst_hold_clear: got msg=%0d vld=%b want 0/0", MSG, MSG_VLD); else pass_cnt++;
    // S1 kept pressed through reset: debounced level restarts low, so a
    // fresh event appears exactly DEB_CYCLES+4 edges after release.
    tick(7);
    total_cnt++;
    if (MSG_VLD !== 1'b0 || MSG !== 4'd0)
      $display("FAIL rst_held_early: got msg=%0d vld=%b want 0/0", MSG, MSG_VLD); else pass_cnt++;
    tick();
    total_cnt++;
    if (MSG_VLD !== 1'b1 || MSG !== 4'd2)
      $display("FAIL rst_held_event: got msg=%0d vld=%b want 2/1", MSG, MSG_VLD); else pass_cnt++;
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick(12);
    total_cnt++;
    if (MSG_VLD !== 1'b0) $display("FAIL held_single_event: got vld=%b want 0", MSG_VLD); else pass_cnt++;
    S1 = 1'b0;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_clean_path();
    test_glitch();
    test_priority();
    test_contention();
    test_mode();
    test_reset_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
